// File: rtl/roteamento_pkg.sv
// Shared definitions for the round-robin routing arbiter.
//   BITS      data word width per requester
//   SEL_BITS  select code width (four requesters -> 2 bits)
//   state_t   arbiter FSM states
//   onehot4   converts a 2-bit select code into a 4-bit one-hot grant
package roteamento_pkg;

    localparam int BITS     = 4;
    localparam int SEL_BITS = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [3:0] onehot4(input logic [1:0] sel);
        onehot4 = 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin winner pick.
//   req    in   4  request vector (bit 0 = A ... bit 3 = D)
//   ptr    in   2  highest-priority index for this pick
//   found  out  1  at least one request is set
//   winner out  2  first set request scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4)
module rr_picker (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       found,
    output logic [1:0] winner
);

    logic [7:0] req_dbl;
    logic [3:0] req_rot;
    logic [1:0] offset;

    // Rotating the doubled vector puts requester ptr at bit 0, so a fixed
    // priority scan on the rotated vector is the round-robin scan.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr +: 4];

    always_comb begin
        offset = 2'd0;
        if (req_rot[0]) begin
            offset = 2'd0;
        end else if (req_rot[1]) begin
            offset = 2'd1;
        end else if (req_rot[2]) begin
            offset = 2'd2;
        end else if (req_rot[3]) begin
            offset = 2'd3;
        end
    end

    assign found  = |req;
    assign winner = ptr + offset;

endmodule

// File: rtl/arbitro_roteamento.sv
// Round-robin arbiter sharing one 4:1 routing path among requesters A..D.
// A granted requester keeps the path while it requests, for at most
// HOLD_MAX consecutive transfers, then the grant rotates.
//   clk        in   1         rising-edge clock
//   reset      in   1         asynchronous active-high reset
//   req        in   4         requests (bit 0 = A ... bit 3 = D)
//   A,B,C,D    in   BITS      requester data words
//   SEL        out  SEL_BITS  registered index of the granted requester
//   gnt        out  4         registered one-hot grant, zero when idle
//   Saida      out  BITS      registered routed word
//   valid      out  1         Saida holds a word transferred on the last edge
module arbitro_roteamento
    import roteamento_pkg::*;
#(
    parameter int BITS     = roteamento_pkg::BITS,
    parameter int HOLD_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          req,
    input  logic [BITS-1:0]     A,
    input  logic [BITS-1:0]     B,
    input  logic [BITS-1:0]     C,
    input  logic [BITS-1:0]     D,
    output logic [SEL_BITS-1:0] SEL,
    output logic [3:0]          gnt,
    output logic [BITS-1:0]     Saida,
    output logic                valid
);

    localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

    state_t          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [1:0]      sel_q, sel_d;
    logic [3:0]      gnt_q, gnt_d;
    logic [BITS-1:0] saida_q, saida_d;
    logic            valid_q, valid_d;

    logic [1:0]      pick_ptr;
    logic            found;
    logic [1:0]      winner;
    logic [BITS-1:0] data_sel;
    logic            r;
    logic            release_w;

    // While granted, the only pick that matters is the re-pick on release,
    // which starts just after the current holder.
    assign pick_ptr = (state_q == GRANT) ? (sel_q + 2'd1) : ptr_q;

    rr_picker u_picker (
        .req    (req),
        .ptr    (pick_ptr),
        .found  (found),
        .winner (winner)
    );

    always_comb begin
        case (sel_q)
            2'd0:    data_sel = A;
            2'd1:    data_sel = B;
            2'd2:    data_sel = C;
            default: data_sel = D;
        endcase
    end

    assign r         = req[sel_q];
    assign release_w = !r || ((cnt_q + 4'd1) == HOLD_LIM);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        saida_d = saida_q;
        valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                gnt_d = 4'b0000;
                if (found) begin
                    state_d = GRANT;
                    sel_d   = winner;
                    gnt_d   = onehot4(winner);
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                if (r) begin
                    saida_d = data_sel;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + 4'd1;
                end
                // The last transfer of a window and the handover share an edge.
                if (release_w) begin
                    ptr_d = sel_q + 2'd1;
                    if (found) begin
                        sel_d = winner;
                        gnt_d = onehot4(winner);
                        cnt_d = 4'd0;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= 4'd0;
            sel_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            saida_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            saida_q <= saida_d;
            valid_q <= valid_d;
        end
    end

    assign SEL   = sel_q;
    assign gnt   = gnt_q;
    assign Saida = saida_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_arbitro_roteamento.sv
module tb_arbitro_roteamento;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] req2 = 4'b0000;
    logic [3:0] A = 4'h1, B = 4'h2, C = 4'h3, D = 4'h4;

    logic [1:0] SEL, SEL2;
    logic [3:0] gnt, gnt2;
    logic [3:0] Saida, Saida2;
    logic       valid, valid2;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    arbitro_roteamento #(.BITS(4), .HOLD_MAX(4)) dut (
        .clk(clk), .reset(reset), .req(req),
        .A(A), .B(B), .C(C), .D(D),
        .SEL(SEL), .gnt(gnt), .Saida(Saida), .valid(valid)
    );

    arbitro_roteamento #(.BITS(4), .HOLD_MAX(1)) dut1 (
        .clk(clk), .reset(reset), .req(req2),
        .A(A), .B(B), .C(C), .D(D),
        .SEL(SEL2), .gnt(gnt2), .Saida(Saida2), .valid(valid2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] eg;
        logic [3:0] es;

        // reset state
        #1 reset = 1'b1;
        #1;
        chk("rst_sel", 32'(SEL), 0);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_saida", 32'(Saida), 0);
        chk("rst_valid", 32'(valid), 0);
        #1 reset = 1'b0;

        // single stream: B only
        B   = 4'h5;
        req = 4'b0010;
        step();
        chk("ss_gnt1", 32'(gnt), 32'h2);
        chk("ss_sel1", 32'(SEL), 1);
        chk("ss_valid1", 32'(valid), 0);
        for (int k = 2; k <= 9; k++) begin
            step();
            chk("ss_valid", 32'(valid), 1);
            chk("ss_saida", 32'(Saida), 32'h5);
            chk("ss_gnt", 32'(gnt), 32'h2);
        end
        req = 4'b0000;
        step();
        chk("ss_end_valid", 32'(valid), 0);
        chk("ss_end_gnt", 32'(gnt), 0);
        chk("ss_end_sel", 32'(SEL), 1);
        chk("ss_end_saida", 32'(Saida), 32'h5);

        // full load
        pulse_reset();
        A = 4'h1; B = 4'h2; C = 4'h3; D = 4'h4;
        req = 4'b1111;
        step();
        chk("fl_gnt1", 32'(gnt), 32'h1);
        chk("fl_valid1", 32'(valid), 0);
        for (int k = 2; k <= 21; k++) begin
            es = 4'(((k - 2) / 4) % 4 + 1);
            eg = 4'b0001 << (((k - 1) / 4) % 4);
            step();
            chk("fl_valid", 32'(valid), 1);
            chk("fl_saida", 32'(Saida), 32'(es));
            chk("fl_gnt", 32'(gnt), 32'(eg));
        end

        // asynchronous reset mid-window, no clock edge
        reset = 1'b1;
        #1;
        chk("mr_sel", 32'(SEL), 0);
        chk("mr_gnt", 32'(gnt), 0);
        chk("mr_saida", 32'(Saida), 0);
        chk("mr_valid", 32'(valid), 0);
        reset = 1'b0;
        step();
        chk("mr_idle_gnt", 32'(gnt), 32'h1);
        chk("mr_idle_valid", 32'(valid), 0);
        req = 4'b0000;
        step();
        chk("mr_off_gnt", 32'(gnt), 0);

        // early drop of C, then D, then pointer fairness A before C
        pulse_reset();
        C = 4'h9; D = 4'hA; A = 4'h6;
        req = 4'b1100;
        step();
        chk("ed_gnt1", 32'(gnt), 32'h4);
        chk("ed_sel1", 32'(SEL), 2);
        for (int k = 2; k <= 3; k++) begin
            step();
            chk("ed_c_valid", 32'(valid), 1);
            chk("ed_c_saida", 32'(Saida), 32'h9);
        end
        req = 4'b1000;
        step();
        chk("ed_drop_valid", 32'(valid), 0);
        chk("ed_drop_saida", 32'(Saida), 32'h9);
        chk("ed_drop_gnt", 32'(gnt), 32'h8);
        chk("ed_drop_sel", 32'(SEL), 3);
        for (int k = 5; k <= 7; k++) begin
            step();
            chk("ed_d_valid", 32'(valid), 1);
            chk("ed_d_saida", 32'(Saida), 32'hA);
            chk("ed_d_gnt", 32'(gnt), 32'h8);
        end
        req = 4'b1101;
        step();
        chk("pf_last_d_saida", 32'(Saida), 32'hA);
        chk("pf_last_d_valid", 32'(valid), 1);
        chk("pf_a_gnt", 32'(gnt), 32'h1);
        chk("pf_a_sel", 32'(SEL), 0);
        req = 4'b0101;
        for (int k = 9; k <= 11; k++) begin
            step();
            chk("pf_a_saida", 32'(Saida), 32'h6);
            chk("pf_a_hold", 32'(gnt), 32'h1);
        end
        step();
        chk("pf_a_last", 32'(Saida), 32'h6);
        chk("pf_c_gnt", 32'(gnt), 32'h4);
        chk("pf_c_sel", 32'(SEL), 2);
        step();
        chk("pf_c_saida", 32'(Saida), 32'h9);
        chk("pf_c_valid", 32'(valid), 1);
        req = 4'b0000;
        step();

        // HOLD_MAX = 1 instance alternates A and B
        pulse_reset();
        A = 4'h3; B = 4'hC;
        req2 = 4'b0011;
        step();
        chk("h1_gnt1", 32'(gnt2), 32'h1);
        chk("h1_valid1", 32'(valid2), 0);
        for (int k = 2; k <= 9; k++) begin
            es = (k % 2 == 0) ? 4'h3 : 4'hC;
            eg = (k % 2 == 0) ? 4'b0010 : 4'b0001;
            step();
            chk("h1_valid", 32'(valid2), 1);
            chk("h1_saida", 32'(Saida2), 32'(es));
            chk("h1_gnt", 32'(gnt2), 32'(eg));
        end
        req2 = 4'b0000;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
